// File: rtl/control_logic_fsm_if.sv
// Instruction-memory fetch port of control_logic_fsm.
// Handshake: the master raises imem_req with instr_addr stable and holds both until a rising edge
// that sees imem_valid=1; that edge transfers imem_rdata. imem_valid is ignored while imem_req=0.
interface control_logic_fsm_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  instr_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output instr_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input instr_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/control_logic_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC control unit owning the PC, with conditional branch and HALT.
// Define CL_ILLEGAL_TRAP_EN to make opcode 0xE set a sticky illegal_instr flag and halt.
module control_logic_fsm #(
    parameter int                INSTR_W   = 16,
    parameter int                ADDR_W    = 8,
    parameter int                REG_SEL_W = 3,
    parameter int                IMM_W     = 6,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    control_logic_fsm_if.master  imem,
    input  logic                 zero_flag,
    output logic                 PC_select,
    output logic [ADDR_W-1:0]    Jump_addr,
    output logic                 Source2_select,
    output logic                 ALU_out_Select,
    output logic [IMM_W-1:0]     Immediate_Addr,
    output logic [REG_SEL_W-1:0] Rreg_Sig1,
    output logic [REG_SEL_W-1:0] Rreg_Sig2,
    output logic [REG_SEL_W-1:0] Wreg_Sig,
    output logic [3:0]           OPCODE,
    output logic                 wr_en,
    output logic                 halted,
    output logic                 illegal_instr,
    output logic [2:0]           dbg_state
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BEQZ = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               req_q;
    logic               wr_q;
    logic               halted_q;
    logic               src2_q;
    logic               alu_q;
    logic [3:0]         fetch_op;
    logic               writes_reg;
    logic               jump_taken;
    logic               stop_exec;

    assign fetch_op = imem.imem_rdata[INSTR_W-1 -: 4];

    // Field outputs are straight slices of IR, so they hold from DECODE until the next fetch lands.
    assign OPCODE         = ir[INSTR_W-1 -: 4];
    assign Wreg_Sig       = ir[INSTR_W-5 -: REG_SEL_W];
    assign Rreg_Sig1      = ir[INSTR_W-5-REG_SEL_W -: REG_SEL_W];
    assign Rreg_Sig2      = ir[INSTR_W-5-2*REG_SEL_W -: REG_SEL_W];
    assign Immediate_Addr = ir[IMM_W-1:0];
    assign Jump_addr      = ir[ADDR_W-1:0];

    assign writes_reg = (OPCODE != 4'h0) && (OPCODE <= OP_LDI);
    assign jump_taken = (OPCODE == OP_JMP) || ((OPCODE == OP_BEQZ) && zero_flag);
    // zero_flag is only live in EXEC, so the branch decision cannot be registered ahead of it.
    assign PC_select  = (state == S_EXEC) && jump_taken;

`ifdef CL_ILLEGAL_TRAP_EN
    localparam logic [3:0] OP_RSVD = 4'hE;
    logic illegal_q;
    assign stop_exec     = (OPCODE == OP_HALT) || (OPCODE == OP_RSVD);
    assign illegal_instr = illegal_q;
`else
    assign stop_exec     = (OPCODE == OP_HALT);
    assign illegal_instr = 1'b0;
`endif

    assign imem.imem_req   = req_q;
    assign imem.instr_addr = pc;
    assign wr_en           = wr_q;
    assign halted          = halted_q;
    assign Source2_select  = src2_q;
    assign ALU_out_Select  = alu_q;
    assign dbg_state       = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_RESET;
            pc       <= RESET_PC;
            ir       <= '0;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            halted_q <= 1'b0;
            src2_q   <= 1'b0;
            alu_q    <= 1'b0;
`ifdef CL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        ir     <= imem.imem_rdata;
                        src2_q <= (fetch_op >= 4'h8) && (fetch_op <= 4'hA);
                        alu_q  <= (fetch_op != 4'h0) && (fetch_op <= 4'hA);
                        req_q  <= 1'b0;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    wr_q  <= writes_reg;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wr_q <= 1'b0;
                    if (stop_exec) begin
                        halted_q <= 1'b1;
                        state    <= S_HALT;
`ifdef CL_ILLEGAL_TRAP_EN
                        illegal_q <= illegal_q | (OPCODE == OP_RSVD);
`endif
                    end else begin
                        pc    <= PC_select ? Jump_addr : pc + ADDR_W'(1);
                        req_q <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end
endmodule
